// File: rtl/keypad_entry_if.sv
// Keypad-side wiring plus the operand-entry outputs handed to the datapath/FSM.
interface keypad_entry_if;
  logic [3:0]  row_n;
  logic        enter_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] Din;
  logic [2:0]  digit_count;
  logic        next;

  modport master (input row_n, enter_n,
                  output col_n, key_valid, key_code, Din, digit_count, next);
  modport slave  (output row_n, enter_n,
                  input col_n, key_valid, key_code, Din, digit_count, next);
endinterface

// File: rtl/keypad_entry.sv
// 4x4 hex keypad + Enter scanner: debounces whole-scan results and shifts accepted
// nibbles into a 16-bit operand; an accepted Enter commits it with a one-cycle next pulse.
module keypad_entry #(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic           clk,
  input  logic           clear,
  keypad_entry_if.master kp
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_SCANS);

  typedef struct packed {
    logic       vld;
    logic [3:0] code;
  } key_t;

  logic [3:0]    row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic          ent_s1_q, ent_s1_d, ent_s2_q, ent_s2_d;
  logic [CW-1:0] slot_q, slot_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    hcode_q, hcode_d;
  key_t          kprev_q, kprev_d, kacc_q, kacc_d;
  logic [DW-1:0] kcnt_q, kcnt_d, ecnt_q, ecnt_d;
  logic          eprev_q, eprev_d, eacc_q, eacc_d;
  logic          key_valid_q, key_valid_d, next_q, next_d, fresh_q, fresh_d;
  logic [3:0]    key_code_q, key_code_d;
  logic [15:0]   din_q, din_d;
  logic [2:0]    dcnt_q, dcnt_d;

  logic          tick, key_ev, ent_ev, eres;
  logic [3:0]    rows;
  logic [2:0]    nrow, sum;
  logic [1:0]    ridx, base;
  logic [DW-1:0] kcnt_n, ecnt_n;
  key_t          kres;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      ent_s1_q    <= 1'b1;
      ent_s2_q    <= 1'b1;
      slot_q      <= '0;
      col_q       <= '0;
      hits_q      <= '0;
      hcode_q     <= '0;
      kprev_q     <= '0;
      kacc_q      <= '0;
      kcnt_q      <= '0;
      ecnt_q      <= '0;
      eprev_q     <= 1'b0;
      eacc_q      <= 1'b0;
      key_valid_q <= 1'b0;
      next_q      <= 1'b0;
      fresh_q     <= 1'b0;
      key_code_q  <= '0;
      din_q       <= '0;
      dcnt_q      <= '0;
    end else begin
      row_s1_q    <= row_s1_d;
      row_s2_q    <= row_s2_d;
      ent_s1_q    <= ent_s1_d;
      ent_s2_q    <= ent_s2_d;
      slot_q      <= slot_d;
      col_q       <= col_d;
      hits_q      <= hits_d;
      hcode_q     <= hcode_d;
      kprev_q     <= kprev_d;
      kacc_q      <= kacc_d;
      kcnt_q      <= kcnt_d;
      ecnt_q      <= ecnt_d;
      eprev_q     <= eprev_d;
      eacc_q      <= eacc_d;
      key_valid_q <= key_valid_d;
      next_q      <= next_d;
      fresh_q     <= fresh_d;
      key_code_q  <= key_code_d;
      din_q       <= din_d;
      dcnt_q      <= dcnt_d;
    end
  end

  always_comb begin
    row_s1_d    = kp.row_n;
    row_s2_d    = row_s1_q;
    ent_s1_d    = kp.enter_n;
    ent_s2_d    = ent_s1_q;
    slot_d      = slot_q;
    col_d       = col_q;
    hits_d      = hits_q;
    hcode_d     = hcode_q;
    kprev_d     = kprev_q;
    kacc_d      = kacc_q;
    kcnt_d      = kcnt_q;
    ecnt_d      = ecnt_q;
    eprev_d     = eprev_q;
    eacc_d      = eacc_q;
    key_valid_d = 1'b0;
    next_d      = 1'b0;
    fresh_d     = fresh_q;
    key_code_d  = key_code_q;
    din_d       = din_q;
    dcnt_d      = dcnt_q;
    rows        = ~row_s2_q;
    nrow        = '0;
    ridx        = '0;
    base        = '0;
    sum         = '0;
    kres        = '0;
    kcnt_n      = kcnt_q;
    ecnt_n      = ecnt_q;
    key_ev      = 1'b0;
    ent_ev      = 1'b0;
    eres        = 1'b0;

    tick   = (slot_q == CW'(SCAN_DIV - 1));
    slot_d = tick ? '0 : slot_q + 1'b1;

    if (tick) begin
      col_d = col_q + 2'd1;
      for (int r = 0; r < 4; r++) begin
        if (rows[r]) begin
          nrow = nrow + 3'd1;
          ridx = 2'(r);
        end
      end
      // Hit count restarts at column 0 and saturates at 2 (2+ means ambiguous).
      base   = (col_q == 2'd0) ? 2'd0 : hits_q;
      sum    = {1'b0, base} + nrow;
      hits_d = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      if (nrow == 3'd1) hcode_d = {ridx, col_q};

      if (col_q == 2'd3) begin
        kres    = (hits_d == 2'd1) ? '{vld: 1'b1, code: hcode_d} : '0;
        kcnt_n  = (kres == kprev_q) ? ((kcnt_q == DMAX) ? DMAX : kcnt_q + 1'b1) : DW'(1);
        kprev_d = kres;
        kcnt_d  = kcnt_n;
        if (kcnt_n == DMAX && kres != kacc_q) begin
          kacc_d = kres;
          key_ev = kres.vld;
        end

        eres    = ~ent_s2_q;
        ecnt_n  = (eres == eprev_q) ? ((ecnt_q == DMAX) ? DMAX : ecnt_q + 1'b1) : DW'(1);
        eprev_d = eres;
        ecnt_d  = ecnt_n;
        if (ecnt_n == DMAX && eres != eacc_q) begin
          eacc_d = eres;
          ent_ev = eres;
        end

        // Enter wins a same-scan tie; the key is still marked accepted so it won't repeat.
        if (ent_ev) begin
          if (dcnt_q != 3'd0) begin
            next_d  = 1'b1;
            dcnt_d  = '0;
            fresh_d = 1'b1;
          end
        end else if (key_ev) begin
          key_valid_d = 1'b1;
          key_code_d  = kres.code;
          if (fresh_q) begin
            din_d   = {12'h000, kres.code};
            dcnt_d  = 3'd1;
            fresh_d = 1'b0;
          end else begin
            din_d  = {din_q[11:0], kres.code};
            dcnt_d = (dcnt_q == 3'd4) ? 3'd4 : dcnt_q + 3'd1;
          end
        end
      end
    end
  end

  assign kp.col_n       = ~(4'b0001 << col_q);
  assign kp.key_valid   = key_valid_q;
  assign kp.key_code    = key_code_q;
  assign kp.Din         = din_q;
  assign kp.digit_count = dcnt_q;
  assign kp.next        = next_q;
endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart to the LED display path: scans a 4x4 hex keypad and an Enter pushbutton, debounces both, and assembles the 16-bit operand that feeds the datapath's Din.
- Emits a one-cycle next pulse that commits the entry, replacing the raw next switch at the FSM.
- The display path shows results as four nibbles; this block enters operands the same way, one nibble per key.

Parameters:
SCAN_DIV, 5000, clk cycles per column slot (minimum 2)
DEBOUNCE_SCANS, 4, consecutive identical full-scan results required to accept a key or Enter state (minimum 1)

Ports:
clk  input  1  system clock, rising edge
clear  input  1  asynchronous, active-low reset
row_n  input  4  keypad rows, active-low (pulled up), asynchronous to clk
enter_n  input  1  Enter pushbutton, active-low, asynchronous to clk
col_n  output  4  keypad column drive, one-cold
key_valid  output  1  one-cycle pulse on an accepted key press
key_code  output  4  code of the last accepted key, 0x0-0xF
Din  output  16  assembled operand, newest nibble in [3:0]
digit_count  output  3  nibbles entered since last commit, 0-4
next  output  1  one-cycle commit pulse

Behaviour:
- Reset (clear low, async), outputs: col_n=4'b1110, key_valid=0, key_code=0, Din=0, digit_count=0, next=0. Internal: slot counter=0, column=0, debounce counters=0, accepted key=none, accepted enter=released, fresh=0.
- Synchronisers: row_n and enter_n each pass through a 2-flop synchroniser before use.
- Column scan:
  - Slot counter counts 0..SCAN_DIV-1.
  - Rows are sampled at count SCAN_DIV-1 for settling.
  - Column then advances 0->1->2->3->0; col_n drives the active column low.
- Full-scan result, formed when column 3 is sampled:
  - Exactly one active row/column intersection: key code = row*4 + col.
  - Zero intersections, or two or more: none.
- Key debounce:
  - If the result equals the previous result, the counter increments (saturating); otherwise it reloads to 1.
  - When the counter reaches DEBOUNCE_SCANS, the result becomes the accepted key.
  - If the accepted key goes none->K (or K1->K2 without passing through none), key_valid pulses for the cycle after the accept and key_code <= K.
  - Holding a key produces no repeats; a new press needs a fresh accept.
- Enter debounce:
  - enter_n is sampled once per full scan, at the same tick as the key result.
  - Acceptance uses an identical DEBOUNCE_SCANS rule.
  - Accepted released->pressed produces an enter event.
- Entry register, on key_valid:
  - fresh=1: Din <= {12'h000, K}, digit_count <= 1, fresh <= 0.
  - Otherwise: Din <= {Din[11:0], K}, digit_count <= min(digit_count+1, 4). The oldest nibble is dropped when already 4.
- Commit, on enter event:
  - digit_count != 0: next=1 for exactly one cycle, digit_count <= 0, fresh <= 1. Din holds its value until the next key.
  - digit_count == 0: no pulse; state unchanged.
- Simultaneous events: key and enter are accepted on the same scan tick. Enter is processed; the key event is discarded (no key_valid, key_code unchanged).
- Latency: from a stable press to key_valid is DEBOUNCE_SCANS full scans, measured to the end of the scan in which the press was first seen, plus 1 cycle.
- Reset mid-operation: every register returns to its reset value immediately. An in-progress debounce is lost, and a key held through reset release must re-accept.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2):
- Reset check: clear low, then released -> col_n=1110; Din=0, digit_count=0, next=0; col_n then rotates 1110->1101->1011->0111 every 4 cycles.
- Single press: hold row1/col2 (code 6) for 3 full scans -> exactly one key_valid, key_code=6, Din=0x0006, digit_count=1; no further pulses while held.
- Four keys plus Enter: enter 1,2,3,4 then press Enter -> Din=0x1234, digit_count=4, one-cycle next. Then key 9 -> Din=0x0009, digit_count=1.
- Overflow: enter A,B,C,D,E -> Din=0xBCDE, digit_count=4.
- Debounce rejection:
  - Key 5 toggling every scan, or present for only 1 scan -> no key_valid.
  - Two keys pressed together -> no key_valid.
- Enter edge cases:
  - Enter with digit_count=0 -> no next.
  - Enter and key 3 accepted on the same scan tick -> next pulses; key_code unchanged; digit_count=0.
  - clear asserted mid-debounce -> all outputs return to reset values.
